// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, start/done handshake.
// Optional SERIAL_SUB_SAT_EN: clamp diff to 0 when the final borrow is set.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             x, y, dbit, br_nx;
  logic [WIDTH-1:0] res_nx;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  // Full-subtractor cell, next-state and register updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    x       = a_q[0];
    y       = b_q[0];
    dbit    = x ^ y ^ br_q;
    br_nx   = (~x & y) | (~(x ^ y) & br_q);
    res_nx  = {dbit, res_q[WIDTH-1:1]};
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d = res_nx;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = br_nx;
`ifdef SERIAL_SUB_SAT_EN
          diff_d  = br_nx ? '0 : res_nx;
`else
          diff_d  = res_nx;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor, WIDTH = 4.
// Expected values are hand-computed; SERIAL_SUB_SAT_EN selects clamped results.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       bin;
  logic       busy, done, bout;
  logic [3:0] diff;

  int n_run;
  int n_fail;
  int lat;
  int ndone;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SERIAL_SUB_SAT_EN
  localparam logic [3:0] NEG_3_5   = 4'd0;
  localparam logic [3:0] NEG_ONE   = 4'd0;
`else
  localparam logic [3:0] NEG_3_5   = 4'd14;
  localparam logic [3:0] NEG_ONE   = 4'd15;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an op and wait (bounded) for done; lat = edges after accept.
  task automatic op(input logic [3:0] av, input logic [3:0] bv,
                    input logic biv, output int l);
    a     = av;
    b     = bv;
    bin   = biv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    bin   = 1'($urandom);
    l     = 0;
    while (done !== 1'b1 && l < 12) begin
      chk("busy_run", {30'd0, busy, done}, 32'b10);
      tick();
      l++;
    end
    chk("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      chk("reset_idle", {25'd0, busy, done, bout, diff}, 32'd0);
      tick();
    end

    op(4'd5, 4'd3, 1'b0, lat);
    chk("lat_5_3", lat, 4);
    chk("diff_5_3", diff, 4'd2);
    chk("bout_5_3", bout, 1'b0);
    tick();
    chk("done_pulse", {30'd0, busy, done}, 32'd0);
    chk("diff_held", diff, 4'd2);

    op(4'd3, 4'd5, 1'b0, lat);
    chk("lat_3_5", lat, 4);
    chk("diff_3_5", diff, NEG_3_5);
    chk("bout_3_5", bout, 1'b1);
    tick();

    op(4'd15, 4'd15, 1'b1, lat);
    chk("diff_ff1", diff, NEG_ONE);
    chk("bout_ff1", bout, 1'b1);
    op(4'd0, 4'd0, 1'b1, lat);
    chk("b2b_spacing", lat + 1, 5);
    chk("diff_001", diff, NEG_ONE);
    chk("bout_001", bout, 1'b1);
    tick();

    a     = 4'd9;
    b     = 4'd1;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    tick();
    a     = 4'd0;
    b     = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) begin
        ndone++;
        chk("diff_9_1", diff, 4'd8);
        chk("bout_9_1", bout, 1'b0);
      end
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      tick();
    end
    chk("ignore_start_dones", ndone, 1);
    chk("idle_after", {30'd0, busy, done}, 32'd0);

    a     = 4'd6;
    b     = 4'd2;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_reset", {25'd0, busy, done, bout, diff}, 32'd0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("no_done_after_rst", ndone, 0);
    chk("outs_after_rst", {25'd0, busy, done, bout, diff}, 32'd0);

    op(4'd12, 4'd4, 1'b1, lat);
    chk("lat_after_rst", lat, 4);
    chk("diff_12_4_1", diff, 4'd7);
    chk("bout_12_4_1", bout, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
